// File: rtl/bcd_display_scanner.sv
// Time-multiplexed BCD 7-segment scanner with frame-aligned double buffering.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shown).
module bcd_display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    load_pending
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PS_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PS_W-1:0]  LAST_PS  = PS_W'(REFRESH_DIV - 1);
  localparam logic INV = (ACTIVE_LOW != 0);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [PS_W-1:0]         ps, ps_nxt;
  logic [4*NUM_DIGITS-1:0] pending, shadow;
  logic                    slot_end, commit, suppress;
  logic [3:0]              digit;
  logic [6:0]              seg_hi;
  logic [NUM_DIGITS-1:0]   an_hi;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b1000000;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    ps_nxt    = ps;
    slot_end  = (state == DRIVE) && (ps == LAST_PS);
    commit    = slot_end && (idx == LAST_IDX);
    case (state)
      BLANK: begin
        state_nxt = DRIVE;
        ps_nxt    = '0;
      end
      DRIVE: begin
        if (slot_end) begin
          ps_nxt    = '0;
          idx_nxt   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
          state_nxt = BLANK;
        end else begin
          ps_nxt = ps + 1'b1;
        end
      end
      default: state_nxt = BLANK;
    endcase
  end

  // Outputs are computed for the upcoming cycle so the registered pins line up with state.
  always_comb begin
    digit    = '0;
    an_hi    = '0;
    suppress = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_nxt == IDX_W'(i)) digit = shadow[4*i +: 4];
      an_hi[i] = (state_nxt == DRIVE) && (idx_nxt == IDX_W'(i));
    end
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic zero_run;
      zero_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        zero_run = zero_run && (shadow[4*i +: 4] == 4'd0);
        if (idx_nxt == IDX_W'(i)) suppress = zero_run;
      end
    end
`endif
    seg_hi = (state_nxt == DRIVE) ? decode(digit) : 7'b0;
    if (suppress) begin
      an_hi  = '0;
      seg_hi = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= BLANK;
      idx          <= '0;
      ps           <= '0;
      pending      <= '0;
      shadow       <= '0;
      load_pending <= 1'b0;
      seg          <= {7{INV}};
      an           <= {NUM_DIGITS{INV}};
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      ps    <= ps_nxt;
      seg   <= seg_hi ^ {7{INV}};
      an    <= an_hi ^ {NUM_DIGITS{INV}};
      if (commit) begin
        // A load landing on the wrap edge bypasses the pending buffer.
        if (load) begin
          shadow  <= bcd_in;
          pending <= bcd_in;
        end else if (load_pending) begin
          shadow <= pending;
        end
        load_pending <= 1'b0;
      end else if (load) begin
        pending      <= bcd_in;
        load_pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner: 4 digits, 4-cycle slots, active-low pins.
module tb_bcd_display_scanner;
  localparam int FR = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        load_pending;

  int tests = 0;
  int fails = 0;

  logic [3:0] cap_an  [FR];
  logic [6:0] cap_seg [FR];
  logic       cap_lp  [FR];

  bcd_display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .bcd_in(bcd_in), .load(load),
    .seg(seg), .an(an), .load_pending(load_pending)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_ah(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0111111;  4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;  4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;  4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;  4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;  4'd9: return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  // Expected {an,seg} at sample k of a frame (k%5==0 is the blank cycle).
  function automatic logic [10:0] exp_out(input int k, input logic [15:0] v);
    int s;
    logic blank;
    s = k / 5;
    if (k % 5 == 0) return 11'h7FF;
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (s > 0) begin
      blank = 1'b1;
      for (int j = s; j < 4; j++) if (v[4*j +: 4] != 4'd0) blank = 1'b0;
    end
`endif
    if (blank) return 11'h7FF;
    return {~(4'b0001 << s), ~seg_ah(v[4*s +: 4])};
  endfunction

  // Record one frame of outputs starting at a frame-start negedge, pulsing load where asked.
  task automatic grab_frame(input int la, input logic [15:0] va,
                            input int lb, input logic [15:0] vb);
    for (int k = 0; k < FR; k++) begin
      cap_an[k] = an; cap_seg[k] = seg; cap_lp[k] = load_pending;
      if (k == la) begin load = 1'b1; bcd_in = va; end
      else if (k == lb) begin load = 1'b1; bcd_in = vb; end
      else load = 1'b0;
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({an, seg, load_pending} !== {4'hF, 7'h7F, 1'b0}) begin
      fails++;
      $display("FAIL reset_state got an=%b seg=%b lp=%b want 1111 1111111 0", an, seg, load_pending);
    end
    reset = 1'b0;
    grab_frame(-1, 16'h0, -1, 16'h0);
    for (int k = 0; k < FR; k++) begin
      tests++;
      if ({cap_an[k], cap_seg[k]} !== exp_out(k, 16'h0000)) begin
        fails++;
        $display("FAIL reset_frame k=%0d got %b_%b want %b", k, cap_an[k], cap_seg[k], exp_out(k, 16'h0000));
      end
    end
  endtask

  task automatic test_load;
    grab_frame(7, 16'h1234, -1, 16'h0);
    for (int k = 0; k < FR; k++) begin
      tests++;
      if ({cap_an[k], cap_seg[k], cap_lp[k]} !== {exp_out(k, 16'h0000), k >= 8}) begin
        fails++;
        $display("FAIL load_hold k=%0d got %b_%b lp=%b want %b lp=%b", k, cap_an[k], cap_seg[k], cap_lp[k], exp_out(k, 16'h0000), k >= 8);
      end
    end
    grab_frame(-1, 16'h0, -1, 16'h0);
    for (int k = 0; k < FR; k++) begin
      tests++;
      if ({cap_an[k], cap_seg[k], cap_lp[k]} !== {exp_out(k, 16'h1234), 1'b0}) begin
        fails++;
        $display("FAIL load_commit k=%0d got %b_%b lp=%b want %b lp=0", k, cap_an[k], cap_seg[k], cap_lp[k], exp_out(k, 16'h1234));
      end
    end
  endtask

  task automatic test_back_to_back;
    grab_frame(3, 16'h1111, 9, 16'h9999);
    for (int k = 0; k < FR; k++) begin
      tests++;
      if ({cap_an[k], cap_seg[k]} !== exp_out(k, 16'h1234)) begin
        fails++;
        $display("FAIL b2b_hold k=%0d got %b_%b want %b", k, cap_an[k], cap_seg[k], exp_out(k, 16'h1234));
      end
    end
    grab_frame(-1, 16'h0, -1, 16'h0);
    for (int k = 0; k < FR; k++) begin
      tests++;
      if ({cap_an[k], cap_seg[k]} !== exp_out(k, 16'h9999)) begin
        fails++;
        $display("FAIL b2b_last_wins k=%0d got %b_%b want %b", k, cap_an[k], cap_seg[k], exp_out(k, 16'h9999));
      end
    end
  endtask

  task automatic test_wrap_load;
    grab_frame(19, 16'h5678, -1, 16'h0);
    grab_frame(-1, 16'h0, -1, 16'h0);
    for (int k = 0; k < FR; k++) begin
      tests++;
      if ({cap_an[k], cap_seg[k], cap_lp[k]} !== {exp_out(k, 16'h5678), 1'b0}) begin
        fails++;
        $display("FAIL wrap_load k=%0d got %b_%b lp=%b want %b lp=0", k, cap_an[k], cap_seg[k], cap_lp[k], exp_out(k, 16'h5678));
      end
    end
  endtask

  task automatic test_dash;
    grab_frame(10, 16'hFA00, -1, 16'h0);
    grab_frame(-1, 16'h0, -1, 16'h0);
    for (int k = 0; k < FR; k++) begin
      tests++;
      if ({cap_an[k], cap_seg[k]} !== exp_out(k, 16'hFA00)) begin
        fails++;
        $display("FAIL dash k=%0d got %b_%b want %b", k, cap_an[k], cap_seg[k], exp_out(k, 16'hFA00));
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) begin load = 1'b1; bcd_in = 16'h8888; end else load = 1'b0;
      @(negedge clk);
    end
    tests++;
    if ({an, seg, load_pending} !== {exp_out(12, 16'hFA00), 1'b1}) begin
      fails++;
      $display("FAIL mid_pre_reset got %b_%b lp=%b want %b lp=1", an, seg, load_pending, exp_out(12, 16'hFA00));
    end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({an, seg, load_pending} !== {4'hF, 7'h7F, 1'b0}) begin
      fails++;
      $display("FAIL mid_reset got an=%b seg=%b lp=%b want 1111 1111111 0", an, seg, load_pending);
    end
    reset = 1'b0;
    grab_frame(-1, 16'h0, -1, 16'h0);
    for (int k = 0; k < FR; k++) begin
      tests++;
      if ({cap_an[k], cap_seg[k], cap_lp[k]} !== {exp_out(k, 16'h0000), 1'b0}) begin
        fails++;
        $display("FAIL mid_reset_frame k=%0d got %b_%b lp=%b want %b lp=0", k, cap_an[k], cap_seg[k], cap_lp[k], exp_out(k, 16'h0000));
      end
    end
  endtask

  task automatic test_leading_zero;
    grab_frame(5, 16'h0040, -1, 16'h0);
    grab_frame(-1, 16'h0, -1, 16'h0);
    for (int k = 0; k < FR; k++) begin
      tests++;
      if ({cap_an[k], cap_seg[k]} !== exp_out(k, 16'h0040)) begin
        fails++;
        $display("FAIL leading_zero k=%0d got %b_%b want %b", k, cap_an[k], cap_seg[k], exp_out(k, 16'h0040));
      end
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_back_to_back;
    test_wrap_load;
    test_dash;
    test_reset_mid;
    test_leading_zero;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
